// File: rtl/dsp_column_frame_loader.sv
// Column configuration front end: collects a header plus one word per row, then strobes the frame into the tiles.
// Optional running CRC-16-CCITT output is enabled by defining DSP_FRAME_LOADER_CRC_EN.
module dsp_column_frame_loader #(
    parameter int         FrameBitsPerRow = 32,
    parameter int         MaxFramesPerCol = 20,
    parameter int         NumberOfRows    = 2,
    parameter logic [7:0] ColumnID        = 8'd0,
    parameter int         StrobeCycles    = 1
) (
    input  logic                                    UserCLK,
    input  logic                                    Reset,
    input  logic [FrameBitsPerRow-1:0]              WriteData,
    input  logic                                    WriteValid,
    output logic                                    WriteReady,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] RowFrameData,
    output logic [MaxFramesPerCol-1:0]              FrameStrobe,
    output logic                                    Busy,
`ifdef DSP_FRAME_LOADER_CRC_EN
    output logic [15:0]                             CrcOut,
`endif
    output logic                                    Error
);

    localparam int RW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam int SW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam logic [RW-1:0] LastRow = RW'(NumberOfRows - 1);
    localparam logic [SW-1:0] LastStb = SW'(StrobeCycles - 1);
    localparam logic [5:0]    MaxIdx  = 6'(MaxFramesPerCol);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t                                  r_state;
    state_t                                  w_next;
    logic                                    r_valid;
    logic [4:0]                              r_idx;
    logic [RW-1:0]                           r_row;
    logic [SW-1:0]                           r_scnt;
    logic [NumberOfRows*FrameBitsPerRow-1:0] r_rows;
    logic [MaxFramesPerCol-1:0]              r_strobe;
    logic                                    r_error;

    logic                                    w_xfer;
    logic                                    w_hit;
    logic                                    w_bad;
    logic [MaxFramesPerCol-1:0]              w_onehot;

    assign w_xfer   = WriteValid & WriteReady;
    assign w_hit    = (WriteData[15:8] == ColumnID);
    assign w_bad    = ({1'b0, WriteData[4:0]} >= MaxIdx);
    assign w_onehot = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << r_idx;

    assign RowFrameData = r_rows;
    assign FrameStrobe  = r_strobe;
    assign Error        = r_error;

`ifdef DSP_FRAME_LOADER_CRC_EN
    logic [15:0] r_crc;

    // Bitwise CRC-16-CCITT (poly 0x1021), word processed MSB first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                               input logic [FrameBitsPerRow-1:0] data);
        logic [15:0] x;
        logic        fb;
        x = crc;
        for (int i = FrameBitsPerRow - 1; i >= 0; i--) begin
            fb = x[15] ^ data[i];
            x  = {x[14:0], 1'b0};
            if (fb) x = x ^ 16'h1021;
        end
        return x;
    endfunction

    assign CrcOut = r_crc;

    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset)       r_crc <= 16'hFFFF;
        else if (w_xfer) r_crc <= crc16_word(r_crc, WriteData);
    end
`endif

    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_xfer) w_next = S_LOAD;
            S_LOAD:   if (w_xfer && r_row == LastRow) w_next = r_valid ? S_SETUP : S_IDLE;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: if (r_scnt == LastStb) w_next = S_HOLD;
            S_HOLD:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        WriteReady = 1'b0;
        Busy       = (r_state != S_IDLE);
        if (!Reset && (r_state == S_IDLE || r_state == S_LOAD)) WriteReady = 1'b1;
    end

    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_row    <= '0;
            r_scnt   <= '0;
            r_rows   <= '0;
            r_strobe <= '0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_idx   <= WriteData[4:0];
                        r_valid <= w_hit & ~w_bad;
                        r_row   <= '0;
                        if (w_hit & w_bad) r_error <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_row <= r_row + RW'(1);
                        // Discarded frames still walk the row counter but never touch the data.
                        if (r_valid) begin
                            for (int r = 0; r < NumberOfRows; r++) begin
                                if (r_row == RW'(r))
                                    r_rows[r*FrameBitsPerRow +: FrameBitsPerRow] <= WriteData;
                            end
                        end
                    end
                end
                default: ;
            endcase
            r_scnt   <= (r_state == S_STROBE) ? r_scnt + SW'(1) : '0;
            // Registered strobe is high exactly while the FSM sits in STROBE.
            r_strobe <= (w_next == S_STROBE) ? w_onehot : '0;
        end
    end

endmodule

// File: tb/tb_dsp_column_frame_loader.sv
// Directed bench: instance A (1-cycle strobe) carries most vectors, instance B (3-cycle strobe) the stalled handshake.
`timescale 1ns/1ps
module tb_dsp_column_frame_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wd  = '0;
    logic        wv  = 1'b0;
    logic [31:0] wd3 = '0;
    logic        wv3 = 1'b0;

    logic        rdy_a, busy_a, err_a;
    logic [63:0] rows_a;
    logic [19:0] stb_a;
    logic        rdy_b, busy_b, err_b;
    logic [63:0] rows_b;
    logic [19:0] stb_b;
`ifdef DSP_FRAME_LOADER_CRC_EN
    logic [15:0] crc_a, crc_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int sa_cnt = 0;
    int sb_cnt = 0;
    logic [19:0] sa_last = '0;
    logic [19:0] sb_last = '0;

    always #5 clk = ~clk;

    dsp_column_frame_loader #(.StrobeCycles(1)) dut (
        .UserCLK(clk), .Reset(rst), .WriteData(wd), .WriteValid(wv), .WriteReady(rdy_a),
        .RowFrameData(rows_a), .FrameStrobe(stb_a), .Busy(busy_a),
`ifdef DSP_FRAME_LOADER_CRC_EN
        .CrcOut(crc_a),
`endif
        .Error(err_a)
    );

    dsp_column_frame_loader #(.StrobeCycles(3)) dut3 (
        .UserCLK(clk), .Reset(rst), .WriteData(wd3), .WriteValid(wv3), .WriteReady(rdy_b),
        .RowFrameData(rows_b), .FrameStrobe(stb_b), .Busy(busy_b),
`ifdef DSP_FRAME_LOADER_CRC_EN
        .CrcOut(crc_b),
`endif
        .Error(err_b)
    );

    always @(negedge clk) begin
        if (stb_a != 0) begin sa_cnt++; sa_last = stb_a; end
        if (stb_b != 0) begin sb_cnt++; sb_last = stb_b; end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one word to instance A; returns #1 after the edge that transferred it.
    task automatic send(input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        wd = d;
        wv = 1'b1;
        while (!rdy_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_a) chk("send_ready_timeout", 64'(rdy_a), 64'd1);
        @(posedge clk);
        #1;
        wv = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while (busy_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle", 64'(busy_a), 64'd0);
    endtask

    int c0;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_ready", 64'(rdy_a), 64'd0);
        chk("rst_busy",  64'(busy_a), 64'd0);
        chk("rst_rows",  rows_a, 64'd0);
        chk("rst_stb",   64'(stb_a), 64'd0);
        chk("rst_err",   64'(err_a), 64'd0);
`ifdef DSP_FRAME_LOADER_CRC_EN
        chk("rst_crc",   64'(crc_a), 64'hFFFF);
`endif
        @(negedge clk); rst = 1'b0;
        #1;
        chk("idle_ready", 64'(rdy_a), 64'd1);

`ifdef DSP_FRAME_LOADER_CRC_EN
        send(32'h0000_0000);
        chk("crc_zero_word", 64'(crc_a), 64'h84C0);
        send(32'h0000_0000);
        send(32'h0000_0000);
        wait_idle();
`endif

        // Basic frame
        send(32'h0000_0003);
        send(32'hDEAD_BEEF);
        send(32'h1234_5678);
        chk("basic_rows",     rows_a, 64'h1234_5678_DEAD_BEEF);
        chk("basic_setup_rdy", 64'(rdy_a), 64'd0);
        chk("basic_setup_stb", 64'(stb_a), 64'd0);
        @(posedge clk); #1;
        chk("basic_stb",       64'(stb_a), 64'h00008);
        chk("basic_stb_rdy",   64'(rdy_a), 64'd0);
        @(posedge clk); #1;
        chk("basic_hold_stb",  64'(stb_a), 64'd0);
        chk("basic_hold_rdy",  64'(rdy_a), 64'd0);
        chk("basic_hold_busy", 64'(busy_a), 64'd1);
        @(posedge clk); #1;
        chk("basic_back_rdy",  64'(rdy_a), 64'd1);
        chk("basic_back_busy", 64'(busy_a), 64'd0);
        chk("basic_err",       64'(err_a), 64'd0);

        // Column mismatch
        c0 = sa_cnt;
        send(32'h0000_0105);
        send(32'hAAAA_AAAA);
        send(32'h5555_5555);
        chk("mis_busy", 64'(busy_a), 64'd0);
        chk("mis_rdy",  64'(rdy_a), 64'd1);
        chk("mis_rows", rows_a, 64'h1234_5678_DEAD_BEEF);
        chk("mis_err",  64'(err_a), 64'd0);
        repeat (4) @(negedge clk);
        chk("mis_no_stb", 64'(sa_cnt - c0), 64'd0);

        // Bad index, then a good frame at the top index
        c0 = sa_cnt;
        send(32'h0000_0014);
        chk("bad_err_rise", 64'(err_a), 64'd1);
        send(32'h0000_0001);
        send(32'h0000_0002);
        chk("bad_busy", 64'(busy_a), 64'd0);
        chk("bad_rows", rows_a, 64'h1234_5678_DEAD_BEEF);
        repeat (4) @(negedge clk);
        chk("bad_no_stb", 64'(sa_cnt - c0), 64'd0);
        send(32'h0000_0013);
        send(32'h1111_1111);
        send(32'h2222_2222);
        wait_idle();
        chk("i19_cnt",  64'(sa_cnt - c0), 64'd1);
        chk("i19_stb",  64'(sa_last), 64'h80000);
        chk("i19_rows", rows_a, 64'h2222_2222_1111_1111);
        chk("err_sticky", 64'(err_a), 64'd1);

        // Stalled handshake on the 3-cycle-strobe instance
        @(negedge clk); wd3 = 32'h0000_0000; wv3 = 1'b1;
        @(negedge clk); wd3 = 32'hFFFF_FFFF; wv3 = 1'b0;
        @(negedge clk); wd3 = 32'hCAFE_F00D; wv3 = 1'b1;
        @(negedge clk); wd3 = 32'h0F0F_0F0F; wv3 = 1'b0;
        chk("stall_row0", rows_b, 64'h0000_0000_CAFE_F00D);
        @(negedge clk); wd3 = 32'h0BAD_C0DE; wv3 = 1'b1;
        @(negedge clk); wd3 = 32'h3C3C_3C3C; wv3 = 1'b0;
        chk("stall_busy", 64'(busy_b), 64'd1);
        chk("stall_rdy",  64'(rdy_b), 64'd0);
        repeat (8) @(negedge clk);
        chk("stall_rows", rows_b, 64'h0BAD_C0DE_CAFE_F00D);
        chk("stall_cnt",  64'(sb_cnt), 64'd3);
        chk("stall_stb",  64'(sb_last), 64'h00001);
        chk("stall_idle", 64'(busy_b), 64'd0);

        // Reset in the middle of LOAD
        send(32'h0000_0002);
        send(32'h7777_7777);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_rows", rows_a, 64'd0);
        chk("mrst_stb",  64'(stb_a), 64'd0);
        chk("mrst_rdy",  64'(rdy_a), 64'd0);
        chk("mrst_busy", 64'(busy_a), 64'd0);
        chk("mrst_err",  64'(err_a), 64'd0);
        c0 = sa_cnt;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_no_stb", 64'(sa_cnt - c0), 64'd0);
        send(32'h0000_0002);
        send(32'hA5A5_A5A5);
        send(32'h5A5A_5A5A);
        wait_idle();
        chk("post_rows", rows_a, 64'h5A5A_5A5A_A5A5_A5A5);
        chk("post_cnt",  64'(sa_cnt - c0), 64'd1);
        chk("post_stb",  64'(sa_last), 64'h00004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
